// File: rtl/proc_pkg.sv
// Shared definitions for the six-instruction 16-bit processor: opcodes, controller
// states, ALU select codes, instruction field positions and the control bundle.
package proc_pkg;

    localparam int INSTR_W = 16;
    localparam int REG_A_W = 4;
    localparam int DADDR_W = 8;

    localparam int OPC_LSB  = 12;
    localparam int RA_LSB   = 8;
    localparam int RB_LSB   = 4;
    localparam int RC_LSB   = 0;
    localparam int DADR_LSB = 0;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_e;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD_A = 4'd3,
        ST_LOAD_B = 4'd4,
        ST_STORE  = 4'd5,
        ST_ADD    = 4'd6,
        ST_SUB    = 4'd7,
        ST_NOOP   = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    typedef struct packed {
        logic               im_rd;
        logic [DADDR_W-1:0] d_addr;
        logic               d_wr;
        logic               rf_s;
        logic [REG_A_W-1:0] rf_w_addr;
        logic               rf_w_en;
        logic [REG_A_W-1:0] rf_ra_addr;
        logic [REG_A_W-1:0] rf_rb_addr;
        logic [2:0]         alu_s;
    } ctrl_t;

    // Unassigned opcodes (6..15) fall through to NOOP.
    function automatic state_e exec_state(input logic [3:0] opc);
        state_e st;
        case (opc)
            OP_STORE: st = ST_STORE;
            OP_LOAD:  st = ST_LOAD_A;
            OP_ADD:   st = ST_ADD;
            OP_SUB:   st = ST_SUB;
            OP_HALT:  st = ST_HALT;
            default:  st = ST_NOOP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Controller-side bus: instruction ROM port, datapath control lines and debug taps.
interface control_unit_if #(
    parameter int PC_W = 7
);
    logic [PC_W-1:0] IM_addr;
    logic            IM_rd;
    logic [15:0]     IM_q;
    logic [7:0]      D_addr;
    logic            D_wr;
    logic            RF_s;
    logic [3:0]      RF_W_addr;
    logic            RF_W_en;
    logic [3:0]      RF_Ra_addr;
    logic [3:0]      RF_Rb_addr;
    logic [2:0]      ALU_s0;
    logic [PC_W-1:0] PC_out;
    logic [15:0]     IR_out;
    logic [3:0]      State_out;

    modport master (
        output IM_addr, IM_rd, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, PC_out, IR_out, State_out,
        input  IM_q
    );

    modport slave (
        input  IM_addr, IM_rd, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, PC_out, IR_out, State_out,
        output IM_q
    );
endinterface

// File: rtl/control_fsm.sv
// Moore sequencer for the multicycle controller: state register, next-state
// logic and the per-state decode of datapath controls from the IR fields.
module control_fsm
    import proc_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic [3:0]  opcode_i,
    input  logic [11:0] ir_i,
    output state_e      state_o,
    output logic        fetch_o,
    output logic        decode_o,
    output ctrl_t       ctrl_o
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // In DECODE the branch uses the ROM word directly; the IR only loads at the end of it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = exec_state(opcode_i);
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_LOAD_B: state_d = ST_FETCH;
            ST_STORE:  state_d = ST_FETCH;
            ST_ADD:    state_d = ST_FETCH;
            ST_SUB:    state_d = ST_FETCH;
            ST_NOOP:   state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    always_comb begin
        ctrl_o   = '0;
        fetch_o  = 1'b0;
        decode_o = 1'b0;
        case (state_q)
            ST_FETCH: begin
                fetch_o      = 1'b1;
                ctrl_o.im_rd = 1'b1;
            end
            ST_DECODE: begin
                decode_o = 1'b1;
            end
            ST_LOAD_A: begin
                ctrl_o.d_addr = ir_i[DADR_LSB +: DADDR_W];
                ctrl_o.rf_s   = 1'b1;
            end
            ST_LOAD_B: begin
                ctrl_o.d_addr    = ir_i[DADR_LSB +: DADDR_W];
                ctrl_o.rf_s      = 1'b1;
                ctrl_o.rf_w_addr = ir_i[RA_LSB +: REG_A_W];
                ctrl_o.rf_w_en   = 1'b1;
            end
            ST_STORE: begin
                ctrl_o.d_addr     = ir_i[DADR_LSB +: DADDR_W];
                ctrl_o.rf_ra_addr = ir_i[RA_LSB +: REG_A_W];
                ctrl_o.d_wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                ctrl_o.rf_ra_addr = ir_i[RB_LSB +: REG_A_W];
                ctrl_o.rf_rb_addr = ir_i[RC_LSB +: REG_A_W];
                ctrl_o.rf_w_addr  = ir_i[RA_LSB +: REG_A_W];
                ctrl_o.rf_w_en    = 1'b1;
                ctrl_o.alu_s      = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: begin
            end
        endcase
        // A cycle with reset asserted must never commit a write, whatever the state.
        if (srst) begin
            ctrl_o.d_wr    = 1'b0;
            ctrl_o.rf_w_en = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/control_unit.sv
// Multicycle processor controller: holds PC and IR, drives the instruction ROM
// and presents the sequencer's decoded controls to the datapath.
module control_unit
    import proc_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic           Clock,
    input  logic           Reset,
    control_unit_if.master bus
);

    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;

    state_e state;
    logic   fetch;
    logic   decode;
    ctrl_t  ctrl;

    control_fsm u_fsm (
        .clk      (Clock),
        .srst     (Reset),
        .opcode_i (bus.IM_q[OPC_LSB +: 4]),
        .ir_i     (ir_q[11:0]),
        .state_o  (state),
        .fetch_o  (fetch),
        .decode_o (decode),
        .ctrl_o   (ctrl)
    );

    // PC advances once per instruction in FETCH and wraps at the ROM size.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        if (fetch) begin
            pc_d = pc_q + 1'b1;
        end
        if (decode) begin
            ir_d = bus.IM_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign bus.IM_addr    = fetch ? pc_q : '0;
    assign bus.IM_rd      = ctrl.im_rd;
    assign bus.D_addr     = ctrl.d_addr;
    assign bus.D_wr       = ctrl.d_wr;
    assign bus.RF_s       = ctrl.rf_s;
    assign bus.RF_W_addr  = ctrl.rf_w_addr;
    assign bus.RF_W_en    = ctrl.rf_w_en;
    assign bus.RF_Ra_addr = ctrl.rf_ra_addr;
    assign bus.RF_Rb_addr = ctrl.rf_rb_addr;
    assign bus.ALU_s0     = ctrl.alu_s;
    assign bus.PC_out     = pc_q;
    assign bus.IR_out     = ir_q;
    assign bus.State_out  = state;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level program walker predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_control_unit;
    import proc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_unit_if #(.PC_W(7)) bus ();
    control_unit #(.PC_W(7)) dut (.Clock(clk), .Reset(rst), .bus(bus));

    logic [15:0] rom [128];
    logic [15:0] rom_q = '0;
    always @(posedge clk) if (bus.IM_rd === 1'b1) rom_q <= rom[bus.IM_addr];
    assign bus.IM_q = rom_q;

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  im_addr;
        logic        im_rd;
        logic [7:0]  d_addr;
        logic        d_wr;
        logic        rf_s;
        logic [3:0]  w_addr;
        logic        w_en;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic [6:0]  pc;
        logic [15:0] ir;
    } vec_t;

    typedef struct packed {
        logic last;
        vec_t v;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    int   n_pushed = 0;
    int   n_limit = 0;

    function automatic vec_t base_vec(input logic [3:0] st, input logic [6:0] pc, input logic [15:0] ir);
        vec_t v = '0;
        v.st = st; v.pc = pc; v.ir = ir;
        return v;
    endfunction

    function automatic vec_t sample();
        vec_t v;
        v.st = bus.State_out;   v.im_addr = bus.IM_addr;  v.im_rd = bus.IM_rd;
        v.d_addr = bus.D_addr;  v.d_wr = bus.D_wr;       v.rf_s = bus.RF_s;
        v.w_addr = bus.RF_W_addr; v.w_en = bus.RF_W_en;
        v.ra = bus.RF_Ra_addr;  v.rb = bus.RF_Rb_addr;   v.alu = bus.ALU_s0;
        v.pc = bus.PC_out;      v.ir = bus.IR_out;
        return v;
    endfunction

    task automatic push(input vec_t v, input bit last);
        exp_t e;
        if (n_pushed < n_limit) begin
            e.last = last;
            e.v = v;
            exp_q.push_back(e);
            n_pushed++;
        end
    endtask

    // Walk the program instruction by instruction from PC=0, emitting the
    // expected output vector of every cycle starting with the INIT cycle.
    task automatic build_trace(input int n);
        logic [6:0]  pc = '0;
        logic [15:0] ir = '0;
        logic [15:0] ins;
        vec_t v;
        n_limit = n;
        n_pushed = 0;
        push(base_vec(ST_INIT, 7'd0, 16'd0), 1'b0);
        while (n_pushed < n_limit) begin
            ins = rom[pc];
            v = base_vec(ST_FETCH, pc, ir);
            v.im_addr = pc; v.im_rd = 1'b1;
            push(v, 1'b0);
            pc = pc + 7'd1;
            push(base_vec(ST_DECODE, pc, ir), 1'b0);
            ir = ins;
            case (ins[15:12])
                4'd1: begin
                    v = base_vec(ST_STORE, pc, ir);
                    v.d_addr = ins[7:0]; v.ra = ins[11:8]; v.d_wr = 1'b1;
                    push(v, 1'b1);
                end
                4'd2: begin
                    v = base_vec(ST_LOAD_A, pc, ir);
                    v.d_addr = ins[7:0]; v.rf_s = 1'b1;
                    push(v, 1'b0);
                    v.st = ST_LOAD_B; v.w_addr = ins[11:8]; v.w_en = 1'b1;
                    push(v, 1'b1);
                end
                4'd3, 4'd4: begin
                    v = base_vec((ins[15:12] == 4'd3) ? ST_ADD : ST_SUB, pc, ir);
                    v.ra = ins[7:4]; v.rb = ins[3:0]; v.w_addr = ins[11:8]; v.w_en = 1'b1;
                    v.alu = (ins[15:12] == 4'd3) ? 3'd1 : 3'd2;
                    push(v, 1'b1);
                end
                4'd5: begin
                    v = base_vec(ST_HALT, pc, ir);
                    push(v, 1'b1);
                    while (n_pushed < n_limit) push(v, 1'b0);
                end
                default: push(base_vec(ST_NOOP, pc, ir), 1'b1);
            endcase
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        vec_t a;
        if (mon_en) begin
            if (rst) begin
                checks++;
                if (bus.D_wr !== 1'b0 || bus.RF_W_en !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_write_gate: D_wr=%b RF_W_en=%b required 0 0", bus.D_wr, bus.RF_W_en);
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = sample();
                checks++;
                if (a !== e.v) begin
                    errors++;
                    $display("FAIL cycle_vector: state %0d want %0d pc %0d want %0d got %h want %h",
                             a.st, e.v.st, a.pc, e.v.pc, a, e.v);
                end else if (e.last) begin
                    $display("retired ir=%h state=%0d pc_after=%0d", e.v.ir, e.v.st, e.v.pc);
                end
            end
        end
    end

    // Hold reset for two sampled edges, release, then either let the trace
    // drain or re-assert reset after abort_after cycles.
    task automatic run_prog(input int n_vec, input int abort_after);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        build_trace(n_vec);
        rst = 1'b0;
        if (abort_after >= 0) begin
            repeat (abort_after) @(posedge clk);
            #1;
            rst = 1'b1;
            exp_q.delete();
            @(posedge clk); #1;
            checks++;
            if (bus.State_out !== ST_INIT || bus.PC_out !== 7'd0 || bus.IR_out !== 16'd0 ||
                bus.D_wr !== 1'b0 || bus.RF_W_en !== 1'b0 || bus.IM_rd !== 1'b0) begin
                errors++;
                $display("FAIL abort_to_init: state=%0d pc=%0d ir=%h required %0d 0 0000",
                         bus.State_out, bus.PC_out, bus.IR_out, ST_INIT);
            end
        end else begin
            for (int i = 0; i < n_vec + 20 && exp_q.size() != 0; i++) @(posedge clk);
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL trace_drain: %0d left required 0", exp_q.size());
            end
        end
    endtask

    function automatic logic [15:0] rand_instr(input bit allow_halt);
        logic [3:0]  op = 4'($urandom_range(0, 15));
        logic [11:0] f = 12'($urandom);
        if (op == 4'd5 && (!allow_halt || $urandom_range(0, 3) != 0)) op = 4'd3;
        return {op, f};
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        @(posedge clk);
        mon_en = 1;

        rom[0] = 16'h2305; rom[1] = 16'h3A12; rom[2] = 16'h4A12;
        rom[3] = 16'h17FF; rom[4] = 16'hF123; rom[5] = 16'h5000;
        run_prog(45, -1);

        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h2305;
        run_prog(10, 4);

        for (int i = 0; i < 128; i++) rom[i] = rand_instr(1'b0);
        run_prog(700, -1);

        for (int r = 0; r < 10; r++) begin
            int n;
            for (int i = 0; i < 128; i++) rom[i] = rand_instr(1'b1);
            n = $urandom_range(30, 250);
            run_prog(n, (r % 3 == 0) ? $urandom_range(1, n - 2) : -1);
        end

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle controller for the six-instruction 16-bit processor; sits directly upstream of the datapath. Holds the program counter (PC) and instruction register (IR). Fetches from a synchronous instruction ROM and sequences a Moore FSM whose decoded outputs drive every datapath control input. These are data-memory address/write, register-file addresses/enable, write-back mux select and ALU select.

## Interface
Parameters:
- PC_W, 7, PC/instruction-ROM address width (128 words)
- Instruction format: [15:12] opcode, [11:8] Ra (dest/store source), [7:0] data address, or [7:4] Rb / [3:0] Rc for ALU ops

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- IM_addr  out  PC_W  instruction-ROM address
- IM_rd  out  1  instruction-ROM read enable
- IM_q  in  16  instruction-ROM data, valid one cycle after IM_rd
- D_addr  out  8  data-memory address
- D_wr  out  1  data-memory write enable
- RF_s  out  1  write-back select: 1 = memory data, 0 = ALU result
- RF_W_addr  out  4  register-file write address
- RF_W_en  out  1  register-file write enable
- RF_Ra_addr  out  4  register-file read port A address
- RF_Rb_addr  out  4  register-file read port B address
- ALU_s0  out  3  ALU function select
- PC_out  out  PC_W  current PC (debug)
- IR_out  out  16  current IR (debug)
- State_out  out  4  current state encoding (debug)

## Operation
- Opcodes: NOOP 0000, STORE 0001, LOAD 0010, ADD 0011, SUB 0100, HALT 0101. Opcodes 0110–1111 execute as NOOP.
- ALU_s0 codes: PASS 3'd0, ADD 3'd1, SUB 3'd2.
- States: INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, NOOP, HALT.
- Transitions:
  - INIT→FETCH.
  - FETCH→DECODE.
  - DECODE→execute state selected by IM_q[15:12].
  - LOAD_A→LOAD_B→FETCH.
  - STORE/ADD/SUB/NOOP→FETCH.
  - HALT→HALT until Reset.
- Outputs are Moore, decoded from state and IR. Every output not listed for a state is 0.
- FETCH:
  - IM_rd=1, IM_addr=PC.
  - PC←PC+1 at end of cycle, wrapping 127→0.
- DECODE:
  - IR←IM_q at end of cycle.
  - Next state decoded from IM_q, not from IR.
- LOAD_A: D_addr=IR[7:0], RF_s=1 (memory read in flight).
- LOAD_B: D_addr=IR[7:0], RF_s=1, RF_W_addr=IR[11:8], RF_W_en=1.
- STORE: D_addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1.
- ADD/SUB:
  - RF_Ra_addr=IR[7:4], RF_Rb_addr=IR[3:0].
  - RF_W_addr=IR[11:8], RF_W_en=1, RF_s=0.
  - ALU_s0=ADD or SUB respectively.
- HALT: all enables 0, PC frozen, no ROM reads.

## Timing
- Reset:
  - The cycle Reset is sampled high, D_wr and RF_W_en are forced 0 regardless of state, so no write occurs.
  - Next cycle: state=INIT, PC=0, IR=0, and all outputs 0.
- Reset asserted mid-instruction (including LOAD_A, or in HALT) aborts the instruction. Execution restarts at PC=0.
- Instruction latency:
  - NOOP/STORE/ADD/SUB/HALT: 3 cycles (FETCH, DECODE, execute).
  - LOAD: 4 cycles.
- ROM read latency is exactly 1 cycle. No handshake or stalls.
- Data memory is synchronous read: LOAD_B write-back captures the data requested in LOAD_A.
- PC increments exactly once per instruction, during FETCH.

## Structure
- Shared package proc_pkg:
  - opcode enum
  - state enum (4-bit)
  - ALU select constants
  - instruction field positions
- The datapath side imports the same ALU constants.
- One sub-module: control_fsm (state register, next-state logic, output decode). PC and IR registers stay in control_unit top.

## Test plan
- Reset held 2 cycles, then released:
  - State_out shows INIT, then FETCH.
  - IM_addr=0 with IM_rd=1.
  - PC_out=1 after FETCH.
- ROM[0]=16'h2305 (LOAD R3←D[5]):
  - LOAD_A: D_addr=5, RF_s=1.
  - LOAD_B: RF_W_addr=3, RF_W_en=1.
  - Back to FETCH with IM_addr=1, 4 cycles after the first FETCH.
- ROM=16'h3A12 (ADD RA←R1+R2): ADD state shows RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=10, ALU_s0=1, RF_W_en=1, RF_s=0. 16'h4A12 gives the same fields with ALU_s0=2.
- ROM=16'h17FF (STORE D[255]←R7):
  - D_wr=1 for exactly 1 cycle with D_addr=255, RF_Ra_addr=7.
  - RF_W_en stays 0.
- ROM=16'h5000 (HALT): state stays HALT for 20 cycles with IM_rd=0 and PC constant. Reset then returns to INIT.
- Edge cases:
  - Opcode 16'hF123 behaves as NOOP, with no enables asserted.
  - PC at 127 wraps to 0.
  - Reset asserted during LOAD_B gives RF_W_en=0 that cycle, then INIT.
